pipelined_add_sub: RTL
======================

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter S, default 4, meaning pipeline stage count; N mod S SHALL be 0, W = N/S bits per stage; illegal values SHALL fail elaboration.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set present on A/B/Cin/Sub.
REQ-006 in_ready  output  1  block accepts operand set this cycle.
REQ-007 A  input  N  operand A.
REQ-008 B  input  N  operand B.
REQ-009 Cin  input  1  carry-in, add mode only.
REQ-010 Sub  input  1  mode: 0 = A+B+Cin, 1 = A-B.
REQ-011 out_valid  output  1  result present on Sum/Cout/Ovf.
REQ-012 out_ready  input  1  downstream accepts result this cycle.
REQ-013 Sum  output  N  result.
REQ-014 Cout  output  1  carry out of bit N-1; in Sub mode 1 = no borrow.
REQ-015 Ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Transfer in SHALL occur on a cycle with in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-017 Effective operand SHALL be B' = Sub ? ~B : B; carry into bit 0 SHALL be Sub ? 1 : Cin (Cin ignored when Sub=1).
REQ-018 Stage k (0..S-1) SHALL add slice k (bits kW+W-1..kW) of A and B' with the carry registered from stage k-1 (stage 0 uses the REQ-017 carry).
REQ-019 Slices of higher significance SHALL be delayed (operand skew registers) and completed lower slices carried forward (result deskew registers) so all N bits of one transaction emerge together.
REQ-020 Latency SHALL be exactly S cycles from accepting transfer to out_valid, absent stall; S=1 gives a single registered N-bit add.
REQ-021 Throughput SHALL be one transaction per cycle when out_ready is held high.
REQ-022 Stall: when out_valid && !out_ready, every stage (data, carry, valid) SHALL hold; in_ready = !out_valid || out_ready.
REQ-023 Bubbles SHALL propagate with their valid bit low; they are not collapsed.
REQ-024 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-025 Sum = (A + B' + carry0) mod 2^N; Cout = carry out of bit N-1; Ovf = carry into bit N-1 XOR Cout.
REQ-026 Sum/Cout/Ovf SHALL be stable while out_valid && !out_ready.
REQ-027 in_ready SHALL be 0 while rst is high.

Reset
REQ-028 While rst is high at a clock edge, all stage valid bits, out_valid, Sum, Cout, Ovf SHALL clear to 0 on that edge.
REQ-029 Reset mid-operation SHALL discard all in-flight transactions; no stale result SHALL appear after rst deasserts.
REQ-030 First transfer SHALL be accepted in the first cycle after rst deasserts if in_valid is high.

Verification (N=8, S=2 unless stated)
REQ-031 A=0xFF, B=0x01, Cin=0, Sub=0 -> 2 cycles later Sum=0x00, Cout=1, Ovf=0.
REQ-032 A=0x7F, B=0x01, Cin=0, Sub=0 -> Sum=0x80, Cout=0, Ovf=1; A=0x0F, B=0x00, Cin=1 -> Sum=0x10 (carry crosses stage boundary).
REQ-033 Sub=1: A=0x05, B=0x07 -> Sum=0xFE, Cout=0, Ovf=0; A=0x80, B=0x01 -> Sum=0x7F, Cout=1, Ovf=1; Cin=1 ignored.
REQ-034 Four back-to-back transfers, out_ready low 3 cycles after first result -> in_ready=0 during stall, outputs frozen, all four results delivered in order, no loss.
REQ-035 rst pulsed 1 cycle with 2 transactions in flight -> out_valid=0 next cycle, no result for either appears afterwards.
REQ-036 N=32, S=4, 10,000 random transfers with random in_valid/out_ready -> every Sum/Cout/Ovf matches a software model, order preserved.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit adder/subtractor: S stages of W=N/S bits each, with a ripple
// carry between stages and a valid/ready handshake that stalls the whole pipe.

module pipelined_add_sub_stage #(
  parameter int N = 32,
  parameter int W = 8,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         vld_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] s_i,
  input  logic         c_i,
  output logic         vld_o,
  output logic [N-1:0] a_o,
  output logic [N-1:0] b_o,
  output logic [N-1:0] s_o,
  output logic         c_o,
  output logic         ovf_o
);
  logic [W-1:0] a_sl, b_sl;
  logic [W:0]   t;
  logic [N-1:0] s_nxt;

  always_comb begin
    a_sl  = a_i[K*W +: W];
    b_sl  = b_i[K*W +: W];
    t     = {1'b0, a_sl} + {1'b0, b_sl} + {{W{1'b0}}, c_i};
    s_nxt = s_i;
    s_nxt[K*W +: W] = t[W-1:0];
  end

  // Operands ride along so higher slices see this transaction's bits later;
  // finished low slices ride along in s_o until the whole word is done.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_o <= 1'b0;
      a_o   <= '0;
      b_o   <= '0;
      s_o   <= '0;
      c_o   <= 1'b0;
      ovf_o <= 1'b0;
    end else if (en) begin
      vld_o <= vld_i;
      a_o   <= a_i;
      b_o   <= b_i;
      s_o   <= s_nxt;
      c_o   <= t[W];
      // carry into the slice MSB is a^b^sum at that bit
      ovf_o <= a_sl[W-1] ^ b_sl[W-1] ^ t[W-1] ^ t[W];
    end
  end
endmodule

module pipelined_add_sub #(
  parameter int N = 32,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);
  if (S < 1 || N < 1 || (N % S) != 0) begin : g_bad_params
    $fatal(1, "pipelined_add_sub: N must be a positive multiple of S");
  end

  localparam int W = N / S;

  logic [S:0]        vld_pipe;
  logic [S:0][N-1:0] a_pipe, b_pipe, s_pipe;
  logic [S:0]        c_pipe;
  logic [S-1:0]      ovf_v;
  logic              en;
  logic              unused;

  // One enable for every stage: a stalled output freezes the entire pipe.
  assign en        = !out_valid || out_ready;
  assign in_ready  = !rst && en;
  assign out_valid = vld_pipe[S];

  assign vld_pipe[0] = in_valid && in_ready;
  assign a_pipe[0]   = A;
  assign b_pipe[0]   = Sub ? ~B : B;
  assign c_pipe[0]   = Sub ? 1'b1 : Cin;
  assign s_pipe[0]   = '0;

  for (genvar k = 0; k < S; k++) begin : g_stage
    pipelined_add_sub_stage #(.N(N), .W(W), .K(k)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .vld_i (vld_pipe[k]),
      .a_i   (a_pipe[k]),
      .b_i   (b_pipe[k]),
      .s_i   (s_pipe[k]),
      .c_i   (c_pipe[k]),
      .vld_o (vld_pipe[k+1]),
      .a_o   (a_pipe[k+1]),
      .b_o   (b_pipe[k+1]),
      .s_o   (s_pipe[k+1]),
      .c_o   (c_pipe[k+1]),
      .ovf_o (ovf_v[k])
    );
  end

  assign Sum  = s_pipe[S];
  assign Cout = c_pipe[S];
  assign Ovf  = ovf_v[S-1];

  // Final-stage operand copies and lower-stage overflow flags have no reader.
  assign unused = ^{a_pipe[S], b_pipe[S], ovf_v};
endmodule
